// File: rtl/operand_fetch.sv
// Operand fetch stage: latches a decoded instruction, reads both source
// operands from the register file with write-back bypass, and holds the
// result for the execute stage while keeping stalled operands up to date.
module operand_fetch #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic [ADDR_WIDTH-1:0] rf_raddr1,
    output logic [ADDR_WIDTH-1:0] rf_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,
    input  logic                  wb_wen,
    input  logic [ADDR_WIDTH-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_src1,
    output logic [DATA_WIDTH-1:0] out_src2,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [ADDR_WIDTH-1:0] out_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
    logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    logic [DATA_WIDTH-1:0] src1_q, src1_d;
    logic [DATA_WIDTH-1:0] src2_q, src2_d;
    logic [DATA_WIDTH-1:0] out_imm_q, out_imm_d;
    logic [ADDR_WIDTH-1:0] out_rd_q, out_rd_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_hs;

    // Operand select: x0 reads zero, a same-cycle write-back wins over the RF.
    function automatic logic [DATA_WIDTH-1:0] pick_operand(
        input logic [ADDR_WIDTH-1:0] idx,
        input logic [DATA_WIDTH-1:0] rdata,
        input logic                  wen,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata
    );
        if (idx == '0) begin
            return '0;
        end else if (wen && (waddr == idx)) begin
            return wdata;
        end else begin
            return rdata;
        end
    endfunction

    // Upstream ready and handshake detection.
    always_comb begin
        in_ready = !rst && ((state_q == IDLE) || ((state_q == VALID) && out_ready));
        in_hs    = in_valid && in_ready;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        out_imm_d   = out_imm_q;
        out_rd_d    = out_rd_q;
        out_valid_d = out_valid_q;

        if (in_hs) begin
            rs1_d = in_rs1;
            rs2_d = in_rs2;
            rd_d  = in_rd;
            imm_d = in_imm;
        end

        unique case (state_q)
            IDLE: begin
                if (in_hs) begin
                    state_d = READ;
                end
            end
            READ: begin
                src1_d      = pick_operand(rs1_q, rf_rdata1, wb_wen, wb_waddr, wb_wdata);
                src2_d      = pick_operand(rs2_q, rf_rdata2, wb_wen, wb_waddr, wb_wdata);
                out_imm_d   = imm_q;
                out_rd_d    = rd_q;
                out_valid_d = 1'b1;
                state_d     = VALID;
            end
            VALID: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = in_hs ? READ : IDLE;
                end else begin
                    // Keep stalled operands fresh against later write-backs.
                    if (wb_wen && (wb_waddr == rs1_q) && (rs1_q != '0)) begin
                        src1_d = wb_wdata;
                    end
                    if (wb_wen && (wb_waddr == rs2_q) && (rs2_q != '0)) begin
                        src2_d = wb_wdata;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            out_imm_q   <= '0;
            out_rd_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            out_imm_q   <= out_imm_d;
            out_rd_q    <= out_rd_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign rf_raddr1 = rs1_q;
    assign rf_raddr2 = rs2_q;
    assign out_valid = out_valid_q;
    assign out_src1  = src1_q;
    assign out_src2  = src2_q;
    assign out_imm   = out_imm_q;
    assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file and an
// expected-result queue filled at issue time and drained when outputs appear.
module tb_operand_fetch;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    typedef struct {
        logic [DW-1:0] s1;
        logic [DW-1:0] s2;
        logic [DW-1:0] imm;
        logic [AW-1:0] rd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic [DW-1:0] in_imm;
    logic [AW-1:0] rf_raddr1, rf_raddr2;
    logic [DW-1:0] rf_rdata1, rf_rdata2;
    logic          wb_wen;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_src1, out_src2, out_imm;
    logic [AW-1:0] out_rd;

    logic [DW-1:0] rf [32];
    exp_t          sb [$];
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .wb_wen    (wb_wen),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src1  (out_src1),
        .out_src2  (out_src2),
        .out_imm   (out_imm),
        .out_rd    (out_rd)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; commit any write-back into the model RF after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (wb_wen && (wb_waddr != '0)) rf[wb_waddr] = wb_wdata;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic send(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic [DW-1:0] imm);
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_imm   = imm;
        step();
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                        input logic [DW-1:0] imm, input logic [AW-1:0] rd);
        exp_t e;
        e.s1 = s1; e.s2 = s2; e.imm = imm; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_valid"}, DW'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_src1"}, out_src1, e.s1);
            check({tag, "_src2"}, out_src2, e.s2);
            check({tag, "_imm"},  out_imm,  e.imm);
            check({tag, "_rd"},   DW'(out_rd), DW'(e.rd));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
        wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0; out_ready = 1'b1;

        // Reset state
        step(); step();
        smp();
        check("rst_valid", DW'(out_valid), 32'd0);
        check("rst_ready", DW'(in_ready), 32'd0);
        check("rst_src1", out_src1, 32'd0);
        check("rst_raddr1", DW'(rf_raddr1), 32'd0);
        rst = 1'b0;
        smp();
        check("idle_ready", DW'(in_ready), 32'd1);

        // Basic fetch, two-cycle latency
        rf[3] = 32'h11; rf[4] = 32'h22;
        send(5'd3, 5'd4, 5'd5, 32'h8);
        push(32'h11, 32'h22, 32'h8, 5'd5);
        smp();
        check("basic_read_valid", DW'(out_valid), 32'd0);
        check("basic_raddr1", DW'(rf_raddr1), 32'd3);
        check("basic_raddr2", DW'(rf_raddr2), 32'd4);
        step(); smp();
        pop_check("basic");
        step(); smp();
        check("basic_done_valid", DW'(out_valid), 32'd0);

        // x0 reads zero even with a write to x0 in flight
        send(5'd0, 5'd0, 5'd6, 32'hA);
        wb_wen = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFF;
        push(32'h0, 32'h0, 32'hA, 5'd6);
        step(); wb_wen = 1'b0; smp();
        pop_check("x0");
        step();

        // Write-back bypass during READ
        rf[7] = 32'h1;
        send(5'd7, 5'd3, 5'd7, 32'h77);
        wb_wen = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'hABCD;
        push(32'hABCD, 32'h11, 32'h77, 5'd7);
        step(); wb_wen = 1'b0; smp();
        pop_check("bypass");
        step();

        // Stall with operand refresh; new input ignored while not ready
        out_ready = 1'b0;
        send(5'd3, 5'd4, 5'd9, 32'h55);
        push(32'h11, 32'h22, 32'h55, 5'd9);
        step(); smp();
        pop_check("stall1");
        step();
        wb_wen = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'h99;
        in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd3; in_imm = 32'hDEAD;
        smp();
        check("stall_in_ready", DW'(in_ready), 32'd0);
        check("stall2_src2_old", out_src2, 32'h22);
        step(); wb_wen = 1'b0; in_valid = 1'b0; smp();
        check("stall3_valid", DW'(out_valid), 32'd1);
        check("stall3_src2_new", out_src2, 32'h99);
        check("stall3_src1", out_src1, 32'h11);
        check("stall3_rd", DW'(out_rd), 32'd9);
        check("stall3_imm", out_imm, 32'h55);
        check("stall3_raddr1", DW'(rf_raddr1), 32'd3);
        out_ready = 1'b1;
        step(); smp();
        check("stall_release_valid", DW'(out_valid), 32'd0);
        check("stall_release_ready", DW'(in_ready), 32'd1);

        // Back-to-back: second instruction accepted while VALID && out_ready
        send(5'd3, 5'd4, 5'd1, 32'h1);
        push(32'h11, 32'h99, 32'h1, 5'd1);
        step();
        in_valid = 1'b1; in_rs1 = 5'd4; in_rs2 = 5'd3; in_rd = 5'd2; in_imm = 32'h2;
        push(32'h99, 32'h11, 32'h2, 5'd2);
        smp();
        check("b2b_in_ready", DW'(in_ready), 32'd1);
        pop_check("b2b_a");
        step(); in_valid = 1'b0; smp();
        check("b2b_read_valid", DW'(out_valid), 32'd0);
        check("b2b_raddr1", DW'(rf_raddr1), 32'd4);
        step(); smp();
        pop_check("b2b_b");
        step(); smp();
        check("b2b_done_valid", DW'(out_valid), 32'd0);

        // Reset pulse while VALID
        out_ready = 1'b0;
        send(5'd3, 5'd4, 5'd3, 32'h33);
        push(32'h11, 32'h99, 32'h33, 5'd3);
        step(); smp();
        pop_check("prerst");
        rst = 1'b1;
        smp();
        check("rst_hi_ready", DW'(in_ready), 32'd0);
        step(); rst = 1'b0; smp();
        check("rstv_valid", DW'(out_valid), 32'd0);
        check("rstv_src1", out_src1, 32'd0);
        check("rstv_src2", out_src2, 32'd0);
        check("rstv_imm", out_imm, 32'd0);
        check("rstv_rd", DW'(out_rd), 32'd0);
        check("rstv_raddr2", DW'(rf_raddr2), 32'd0);
        check("rstv_ready", DW'(in_ready), 32'd1);

        // Reset during READ aborts the instruction
        out_ready = 1'b1;
        send(5'd3, 5'd4, 5'd4, 32'h44);
        rst = 1'b1;
        step(); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            smp();
            check("rstr_no_valid", DW'(out_valid), 32'd0);
            step();
        end

        check("sb_drained", DW'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Parameters
REQ-001 DATA_WIDTH, 32, operand/immediate width.
REQ-002 ADDR_WIDTH, 5, register index width (32 registers, x0 hardwired zero).

Interface
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  decoded instruction present.
REQ-006 in_ready  out  1  block accepts instruction this cycle.
REQ-007 in_rs1 / in_rs2 / in_rd  in  ADDR_WIDTH each  source and destination indices.
REQ-008 in_imm  in  DATA_WIDTH  immediate, passed through.
REQ-009 rf_raddr1 / rf_raddr2  out  ADDR_WIDTH each  register-file read addresses.
REQ-010 rf_rdata1 / rf_rdata2  in  DATA_WIDTH each  register-file read data, combinational from rf_raddr.
REQ-011 wb_wen, wb_waddr, wb_wdata  in  1 / ADDR_WIDTH / DATA_WIDTH  snoop of register-file write port.
REQ-012 out_valid  out  1  operands ready.
REQ-013 out_ready  in  1  execute stage consumes.
REQ-014 out_src1 / out_src2 / out_imm  out  DATA_WIDTH each; out_rd  out  ADDR_WIDTH.

Function
REQ-015 FSM states IDLE, READ, VALID; reset state IDLE.
REQ-016 in_ready = !rst && (state==IDLE || (state==VALID && out_ready)).
REQ-017 Input handshake (in_valid && in_ready): latch rs1, rs2, rd, imm; next state READ.
REQ-018 READ: rf_raddr1/2 = latched rs1/rs2; capture per operand into out_src, next state VALID, unconditionally (single cycle).
REQ-019 Capture priority per operand: index==0 -> 0; else wb_wen && wb_waddr==index -> wb_wdata (bypass); else rf_rdata.
REQ-020 VALID: out_valid=1; out_src/out_imm/out_rd stable except REQ-021.
REQ-021 VALID with out_valid && !out_ready: wb_wen && wb_waddr==latched index && index!=0 -> that out_src updates to wb_wdata next cycle (operand freshness).
REQ-022 VALID && out_ready: with input handshake -> READ; without -> IDLE, out_valid=0 next cycle.
REQ-023 Latency: input handshake at edge N -> out_valid high from cycle N+2; max throughput one instruction per 2 cycles.
REQ-024 rs1==rs2: both operands receive identical values, including bypass.
REQ-025 Outside READ, rf_raddr1/2 hold latched indices (no functional effect).
REQ-026 out_valid never deasserts without out_ready (no drop); in_valid ignored when in_ready=0.

Reset
REQ-027 rst high at edge: state IDLE; out_valid 0; out_src1, out_src2, out_imm 0; out_rd 0; latched indices and rf_raddr1/2 0.
REQ-028 rst mid-operation (READ or VALID) aborts instruction; no out_valid for it after rst deasserts.
REQ-029 in_ready 0 while rst high.

Verification
REQ-030 Basic: RF x3=0x11, x4=0x22; rs1=3, rs2=4, rd=5, imm=0x8 -> two cycles later out_valid=1, src1=0x11, src2=0x22, imm=0x8, rd=5.
REQ-031 x0: rs1=0, rs2=0, wb_wen=1 waddr=0 wdata=0xFFFF in READ -> src1=src2=0.
REQ-032 READ bypass: rs1=7, RF x7=0x1, wb_wen=1 waddr=7 wdata=0xABCD same cycle -> src1=0xABCD.
REQ-033 Stall update: out_ready=0 three cycles, wb write x4=0x99 in cycle 2 -> src2 0x22 then 0x99; out_valid held; rd/imm unchanged.
REQ-034 Back-to-back: second instruction presented while VALID && out_ready -> accepted same cycle, its out_valid two cycles later, no bubble beyond READ.
REQ-035 Reset in VALID: rst pulsed one cycle -> out_valid 0, outputs 0, state IDLE, in_ready 1 next cycle.
